// File: rtl/word_packer_if.sv
// Handshake bundle between a byte source, the word packer and the vocabulary matcher.
// The byte stream flows in and the packed words flow out on a valid/ready pair.
interface word_packer_if #(
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8
);
  localparam int LEN_W = $clog2(WORD_LENGTH + 1);

  logic [DATA_WIDTH-1:0]             byte_in;
  logic                              byte_valid;
  logic                              byte_last;
  logic                              byte_ready;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word;
  logic [LEN_W-1:0]                  word_len;
  logic                              word_valid;
  logic                              word_ready;

  modport master (
    output byte_in, byte_valid, byte_last, word_ready,
    input  byte_ready, word, word_len, word_valid
  );

  modport slave (
    input  byte_in, byte_valid, byte_last, word_ready,
    output byte_ready, word, word_len, word_valid
  );
endinterface

// File: rtl/word_packer.sv
// Packs a character byte stream into MSB-first, zero-padded fixed-width words.
// Words end on a full word, a delimiter or a byte flagged last.
module word_packer #(
  parameter int                    WORD_LENGTH = 3,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM       = 8'h20,
  parameter bit                    DELIM_EN    = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  word_packer_if.slave bus
);
  localparam int                WW        = WORD_LENGTH * DATA_WIDTH;
  localparam int                LEN_W     = $clog2(WORD_LENGTH + 1);
  localparam logic [LEN_W-1:0]  LAST_SLOT = LEN_W'(WORD_LENGTH - 1);

  logic [WW-1:0]    acc_reg, acc_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [WW-1:0]    word_reg;
  logic [LEN_W-1:0] len_reg;
  logic             valid_reg;

  logic [WW-1:0]    merged;
  logic [WW-1:0]    emit_word;
  logic [LEN_W-1:0] emit_len;
  logic             emit;
  logic             accept;
  logic             is_delim;

  assign bus.byte_ready = ~valid_reg | bus.word_ready;
  assign accept         = bus.byte_valid & bus.byte_ready;
  assign is_delim       = DELIM_EN && (bus.byte_in == DELIM);

  // Accumulator with the incoming byte dropped into slot cnt_reg (slot 0 is the MSB).
  for (genvar gi = 0; gi < WORD_LENGTH; gi++) begin : g_slot
    localparam int HI = (WORD_LENGTH - gi) * DATA_WIDTH - 1;
    assign merged[HI -: DATA_WIDTH] = (cnt_reg == LEN_W'(gi)) ? bus.byte_in
                                                              : acc_reg[HI -: DATA_WIDTH];
  end

  always_comb begin
    emit      = 1'b0;
    emit_word = acc_reg;
    emit_len  = cnt_reg;
    acc_next  = acc_reg;
    cnt_next  = cnt_reg;
    if (accept) begin
      if (is_delim) begin
        // A delimiter only closes a non-empty word; on an empty one it vanishes.
        emit     = (cnt_reg != '0);
        acc_next = '0;
        cnt_next = '0;
      end else if (cnt_reg == LAST_SLOT || bus.byte_last) begin
        emit      = 1'b1;
        emit_word = merged;
        emit_len  = cnt_reg + LEN_W'(1);
        acc_next  = '0;
        cnt_next  = '0;
      end else begin
        acc_next = merged;
        cnt_next = cnt_reg + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      cnt_reg   <= '0;
      word_reg  <= '0;
      len_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      if (emit) begin
        word_reg  <= emit_word;
        len_reg   <= emit_len;
        valid_reg <= 1'b1;
      end else if (valid_reg && bus.word_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.word       = word_reg;
  assign bus.word_len   = len_reg;
  assign bus.word_valid = valid_reg;
endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: directed vector table, reset corner cases,
// a DELIM_EN=0 instance and a randomized run against a queue-based reference model.
module tb_word_packer;
  localparam int WL = 3;
  localparam int DW = 8;
  localparam logic [7:0] SP = 8'h20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_packer_if #(.WORD_LENGTH(WL), .DATA_WIDTH(DW)) bus ();
  word_packer_if #(.WORD_LENGTH(WL), .DATA_WIDTH(DW)) bus0 ();

  word_packer #(.WORD_LENGTH(WL), .DATA_WIDTH(DW), .DELIM(SP), .DELIM_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  word_packer #(.WORD_LENGTH(WL), .DATA_WIDTH(DW), .DELIM(SP), .DELIM_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        l;
    logic        rdy;
    logic        exp_br;
    logic        exp_wv;
    logic [23:0] exp_w;
    logic [1:0]  exp_len;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [7:0] b, input logic v, input logic l, input logic rdy,
                     input logic br, input logic wv, input logic [23:0] w, input logic [1:0] len);
    vec_t r;
    r.b = b; r.v = v; r.l = l; r.rdy = rdy;
    r.exp_br = br; r.exp_wv = wv; r.exp_w = w; r.exp_len = len;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic l, input logic rdy);
    bus.byte_in    = b;
    bus.byte_valid = v;
    bus.byte_last  = l;
    bus.word_ready = rdy;
  endtask

  function automatic logic [23:0] pack(input logic [7:0] q[$]);
    logic [23:0] w = '0;
    for (int i = 0; i < q.size(); i++) w[(WL-1-i)*8 +: 8] = q[i];
    return w;
  endfunction

  initial begin
    logic [7:0]  cur[$];
    logic [23:0] pw[$];
    logic [1:0]  pl[$];
    logic [7:0]  b;
    logic        v, l, r, exp_br, acc, emit;

    drive(8'h00, 1'b0, 1'b0, 1'b1);
    bus0.byte_in = 8'h00; bus0.byte_valid = 1'b0; bus0.byte_last = 1'b0; bus0.word_ready = 1'b1;

    // Directed vectors: inputs for one cycle, expected byte_ready before the edge,
    // expected word outputs after it.
    row(8'h48, 1, 0, 1, 1, 0, 24'h000000, 0);  // full word
    row(8'h65, 1, 0, 1, 1, 0, 24'h000000, 0);
    row(8'h6C, 1, 0, 1, 1, 1, 24'h48656C, 3);
    row(8'h00, 0, 0, 1, 1, 0, 24'h48656C, 3);
    row(8'h48, 1, 0, 1, 1, 0, 24'h48656C, 3);  // partial word via last
    row(8'h69, 1, 1, 1, 1, 1, 24'h486900, 2);
    row(8'h00, 0, 0, 1, 1, 0, 24'h486900, 2);
    row(8'h61, 1, 0, 1, 1, 0, 24'h486900, 2);  // delimiters
    row(SP,    1, 0, 1, 1, 1, 24'h610000, 1);
    row(SP,    1, 0, 1, 1, 0, 24'h610000, 1);
    row(8'h62, 1, 1, 1, 1, 1, 24'h620000, 1);
    row(8'h00, 0, 0, 1, 1, 0, 24'h620000, 1);
    row(8'h41, 1, 0, 0, 1, 0, 24'h620000, 1);  // back-pressure
    row(8'h42, 1, 0, 0, 1, 0, 24'h620000, 1);
    row(8'h43, 1, 0, 0, 1, 1, 24'h414243, 3);
    row(8'h44, 1, 0, 0, 0, 1, 24'h414243, 3);
    row(8'h44, 1, 0, 0, 0, 1, 24'h414243, 3);
    row(8'h44, 1, 0, 1, 1, 0, 24'h414243, 3);
    row(8'h45, 1, 0, 1, 1, 0, 24'h414243, 3);
    row(8'h46, 1, 0, 1, 1, 1, 24'h444546, 3);
    row(8'h00, 0, 0, 1, 1, 0, 24'h444546, 3);

    #2;
    chk("reset.word_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("reset.word", {8'd0, bus.word}, 32'd0);
    chk("reset.word_len", {30'd0, bus.word_len}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.byte_ready", {31'd0, bus.byte_ready}, 32'd1);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].b, tbl[i].v, tbl[i].l, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d.byte_ready", i), {31'd0, bus.byte_ready}, {31'd0, tbl[i].exp_br});
      @(negedge clk);
      chk($sformatf("vec%0d.word_valid", i), {31'd0, bus.word_valid}, {31'd0, tbl[i].exp_wv});
      chk($sformatf("vec%0d.word", i), {8'd0, bus.word}, {8'd0, tbl[i].exp_w});
      chk($sformatf("vec%0d.word_len", i), {30'd0, bus.word_len}, {30'd0, tbl[i].exp_len});
    end

    // Reset while a word is pending output.
    drive(8'h41, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst1.pending", {31'd0, bus.word_valid}, 32'd1);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst1.word_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst1.word", {8'd0, bus.word}, 32'd0);
    chk("rst1.word_len", {30'd0, bus.word_len}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset with a partial word accumulated; stale bytes must not reappear.
    drive(8'h48, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h65, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2.word_valid", {31'd0, bus.word_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h6C, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h6F, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("rst2.word_valid", {31'd0, bus.word_valid}, 32'd1);
    chk("rst2.word", {8'd0, bus.word}, 32'h006C6F00);
    chk("rst2.word_len", {30'd0, bus.word_len}, 32'd2);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst2.drained", {31'd0, bus.word_valid}, 32'd0);

    // Delimiter detection disabled: 0x20 is an ordinary character.
    bus0.byte_valid = 1'b1;
    bus0.byte_in = SP;
    @(negedge clk);
    bus0.byte_in = 8'h61;
    @(negedge clk);
    bus0.byte_in = SP;
    @(negedge clk);
    bus0.byte_valid = 1'b0;
    chk("nodelim.word_valid", {31'd0, bus0.word_valid}, 32'd1);
    chk("nodelim.word", {8'd0, bus0.word}, 32'h00206120);
    chk("nodelim.word_len", {30'd0, bus0.word_len}, 32'd3);

    // Randomized run against a queue model: cur holds the word being built,
    // pw/pl hold the word waiting in the output register.
    for (int c = 0; c < 3000; c++) begin
      chk("rnd.word_valid", {31'd0, bus.word_valid}, {31'd0, (pw.size() > 0)});
      if (pw.size() > 0) begin
        chk("rnd.word", {8'd0, bus.word}, {8'd0, pw[0]});
        chk("rnd.word_len", {30'd0, bus.word_len}, {30'd0, pl[0]});
      end
      b = ($urandom_range(3) == 0) ? SP : 8'($urandom_range(255));
      v = ($urandom_range(9) < 7);
      l = ($urandom_range(9) < 2);
      r = ($urandom_range(9) < 6);
      drive(b, v, l, r);
      #1;
      exp_br = (pw.size() == 0) || r;
      chk("rnd.byte_ready", {31'd0, bus.byte_ready}, {31'd0, exp_br});
      acc = v && exp_br;
      if (pw.size() > 0 && r) begin
        void'(pw.pop_front());
        void'(pl.pop_front());
      end
      if (acc) begin
        emit = 1'b0;
        if (b == SP) begin
          emit = (cur.size() > 0);
        end else begin
          cur.push_back(b);
          emit = (cur.size() == WL) || l;
        end
        if (emit) begin
          pw.push_back(pack(cur));
          pl.push_back(2'(cur.size()));
        end
        if (emit || b == SP) cur.delete();
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
